// File: rtl/clock_divider_multi.sv
// clock_divider_multi: CHANNELS independent, runtime-programmable clock dividers
// driven from one system clock. Each channel emits a one-cycle tick per period.
// With CLKDIV_DUTY_OUT_EN defined it also emits a near-50% duty square wave;
// otherwise clock_out is tied low. New divisors arrive through a valid/ready
// handshake and take effect only at period boundaries on running channels.
module clock_divider_multi #(
  parameter int               CHANNELS    = 4,
  parameter int               WIDTH       = 28,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = 28'd50000000,
  localparam int              CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock_in,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] enable,
  input  logic                sync_clear,
  input  logic                load_valid,
  input  logic [CW-1:0]       load_chan,
  input  logic [WIDTH-1:0]    load_div,
  output logic                load_ready,
  output logic [CHANNELS-1:0] tick_out,
  output logic [CHANNELS-1:0] clock_out
);

  // A divisor of zero would never wrap; treat it as one everywhere.
  localparam logic [WIDTH-1:0] RST_DIV = (DEFAULT_DIV == '0) ? WIDTH'(1) : DEFAULT_DIV;

  logic [CHANNELS-1:0] pend_vec;
  logic                accept;
  logic [WIDTH-1:0]    load_val;

  assign accept   = load_valid && load_ready;
  assign load_val = (load_div == '0) ? WIDTH'(1) : load_div;

  // Ready follows the pending flag of the addressed channel; unknown channels
  // always accept so a stray request cannot stall the writer.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    load_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (load_chan == CW'(i)) load_ready = !pend_vec[i];
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] shd;
    logic             pend;
    logic             tick_q;
    logic             wrap;
    logic             hit;

    // ">=" rather than "==" lets a channel recover if an immediate load on a
    // stopped channel leaves cnt above the new div-1.
    assign wrap        = enable[i] && (cnt >= div - WIDTH'(1));
    assign hit         = accept && (load_chan == CW'(i));
    assign pend_vec[i] = pend;
    assign tick_out[i] = tick_q;

    // Counter, divisor shadowing and tick generation for this channel.
    always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
        // NOTE: shd is reset as well even though it is only read while pend is set; it is a plain register, not a RAM, so the reset is free.
        cnt    <= '0;
        div    <= RST_DIV;
        shd    <= RST_DIV;
        pend   <= 1'b0;
        tick_q <= 1'b0;
      end else if (sync_clear) begin
        cnt    <= '0;
        tick_q <= 1'b0;
        pend   <= 1'b0;
        if (hit)       div <= load_val;
        else if (pend) div <= shd;
      end else begin
        // NOTE: non-blocking assignments so every register sees pre-edge values of cnt/div/pend.
        tick_q <= wrap;
        if (wrap)           cnt <= '0;
        else if (enable[i]) cnt <= cnt + WIDTH'(1);

        if (hit) begin
          // A stopped or wrapping channel is at a safe boundary right now.
          if (!enable[i] || wrap) begin
            div <= load_val;
          end else begin
            shd  <= load_val;
            pend <= 1'b1;
          end
        end else if (wrap && pend) begin
          div  <= shd;
          pend <= 1'b0;
        end
      end
    end

`ifdef CLKDIV_DUTY_OUT_EN
    logic clk_q;
    assign clock_out[i] = clk_q;

    // Square wave: high for the first div/2 counts of each period, lagging cnt by one cycle.
    always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n)                      clk_q <= 1'b0;
      else if (!sync_clear && enable[i]) clk_q <= (cnt < (div >> 1));
    end
`else
    assign clock_out[i] = 1'b0;
`endif
  end : g_ch

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi with CHANNELS=2, WIDTH=8, DEFAULT_DIV=4.
// Inputs change and outputs are sampled on the falling edge of clock_in.
module tb_clock_divider_multi;

`ifdef CLKDIV_DUTY_OUT_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic       clock_in = 1'b0;
  logic       reset_n;
  logic [1:0] enable;
  logic       sync_clear;
  logic       load_valid;
  logic [0:0] load_chan;
  logic [7:0] load_div;
  logic       load_ready;
  logic [1:0] tick_out;
  logic [1:0] clock_out;

  int tests = 0;
  int fails = 0;

  clock_divider_multi #(
    .CHANNELS   (2),
    .WIDTH      (8),
    .DEFAULT_DIV(8'd4)
  ) dut (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .enable    (enable),
    .sync_clear(sync_clear),
    .load_valid(load_valid),
    .load_chan (load_chan),
    .load_div  (load_div),
    .load_ready(load_ready),
    .tick_out  (tick_out),
    .clock_out (clock_out)
  );

  always #5 clock_in = ~clock_in;

  // Counts rising edges until tick_out[ch] is seen; -1 if the budget runs out.
  task automatic wait_tick(input int ch, output int n);
    n = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock_in);
      if (tick_out[ch]) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 2'b00; sync_clear = 1'b0;
    load_valid = 1'b0; load_chan = 1'b0; load_div = 8'd0;
    #12;
    tests++; if (tick_out !== 2'b00) begin fails++; $display("FAIL reset_tick: got %b expected 00", tick_out); end
    tests++; if (clock_out !== 2'b00) begin fails++; $display("FAIL reset_clock: got %b expected 00", clock_out); end
    tests++; if (load_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", load_ready); end
  endtask

  task automatic test_basic();
    logic et, ec;
    @(negedge clock_in);
    reset_n = 1'b1; enable = 2'b11;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock_in);
      et = (k % 4 == 0);
      ec = DUTY && ((k % 4 == 1) || (k % 4 == 2));
      tests++; if (tick_out[0] !== et) begin fails++; $display("FAIL basic_tick0 cyc %0d: got %b expected %b", k, tick_out[0], et); end
      tests++; if (tick_out[1] !== et) begin fails++; $display("FAIL basic_tick1 cyc %0d: got %b expected %b", k, tick_out[1], et); end
      tests++; if (clock_out[0] !== ec) begin fails++; $display("FAIL basic_clk0 cyc %0d: got %b expected %b", k, clock_out[0], ec); end
      tests++; if (clock_out[1] !== ec) begin fails++; $display("FAIL basic_clk1 cyc %0d: got %b expected %b", k, clock_out[1], ec); end
    end
  endtask

  task automatic test_load_deferred();
    int n;
    @(negedge clock_in);  // cnt0 == 1
    load_valid = 1'b1; load_chan = 1'b0; load_div = 8'd6;
    tests++; if (load_ready !== 1'b1) begin fails++; $display("FAIL defer_ready_pre: got %b expected 1", load_ready); end
    @(negedge clock_in);  // accepted, deferred
    load_valid = 1'b0;
    tests++; if (load_ready !== 1'b0) begin fails++; $display("FAIL defer_ready_drop: got %b expected 0", load_ready); end
    tests++; if (tick_out[0] !== 1'b0) begin fails++; $display("FAIL defer_tick_a: got %b expected 0", tick_out[0]); end
    @(negedge clock_in);  // cnt0 == 3
    tests++; if (load_ready !== 1'b0) begin fails++; $display("FAIL defer_ready_hold: got %b expected 0", load_ready); end
    tests++; if (tick_out[0] !== 1'b0) begin fails++; $display("FAIL defer_tick_b: got %b expected 0", tick_out[0]); end
    @(negedge clock_in);  // applying wrap
    tests++; if (tick_out[0] !== 1'b1) begin fails++; $display("FAIL defer_tick_wrap: got %b expected 1", tick_out[0]); end
    tests++; if (load_ready !== 1'b1) begin fails++; $display("FAIL defer_ready_rise: got %b expected 1", load_ready); end
    wait_tick(0, n);
    tests++; if (n !== 6) begin fails++; $display("FAIL defer_gap: got %0d expected 6", n); end
  endtask

  task automatic test_load_zero_disabled();
    int n;
    wait_tick(1, n);  // ch1 last ticked two edges ago
    tests++; if (n !== 2) begin fails++; $display("FAIL zero_align: got %0d expected 2", n); end
    enable = 2'b01; load_valid = 1'b1; load_chan = 1'b1; load_div = 8'd0;
    tests++; if (load_ready !== 1'b1) begin fails++; $display("FAIL zero_ready: got %b expected 1", load_ready); end
    @(negedge clock_in);
    load_valid = 1'b0;
    tests++; if (tick_out[1] !== 1'b0) begin fails++; $display("FAIL zero_tick_disabled: got %b expected 0", tick_out[1]); end
    enable = 2'b11;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock_in);
      tests++; if (tick_out[1] !== 1'b1) begin fails++; $display("FAIL zero_tick cyc %0d: got %b expected 1", k, tick_out[1]); end
      tests++; if (clock_out[1] !== 1'b0) begin fails++; $display("FAIL zero_clk cyc %0d: got %b expected 0", k, clock_out[1]); end
    end
  endtask

  task automatic test_enable_gap();
    int n;
    wait_tick(0, n);
    tests++; if (n !== 4) begin fails++; $display("FAIL gap_align: got %0d expected 4", n); end
    enable = 2'b10; load_valid = 1'b1; load_chan = 1'b0; load_div = 8'd4;
    @(negedge clock_in);  // immediate load on stopped channel
    load_valid = 1'b0; enable = 2'b11;
    tests++; if (tick_out[0] !== 1'b0) begin fails++; $display("FAIL gap_reload_tick: got %b expected 0", tick_out[0]); end
    wait_tick(0, n);
    tests++; if (n !== 4) begin fails++; $display("FAIL gap_reload_period: got %0d expected 4", n); end
    for (int k = 1; k <= 2; k++) begin
      @(negedge clock_in);
      tests++; if (tick_out[0] !== 1'b0) begin fails++; $display("FAIL gap_run_tick cyc %0d: got %b expected 0", k, tick_out[0]); end
    end
    tests++; if (clock_out[0] !== DUTY) begin fails++; $display("FAIL gap_clk_before: got %b expected %b", clock_out[0], DUTY); end
    enable = 2'b10;  // cnt0 == 2
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock_in);
      tests++; if (tick_out[0] !== 1'b0) begin fails++; $display("FAIL gap_off_tick cyc %0d: got %b expected 0", k, tick_out[0]); end
      tests++; if (clock_out[0] !== DUTY) begin fails++; $display("FAIL gap_off_clk cyc %0d: got %b expected %b", k, clock_out[0], DUTY); end
    end
    enable = 2'b11;
    @(negedge clock_in);
    tests++; if (tick_out[0] !== 1'b0) begin fails++; $display("FAIL gap_resume_tick: got %b expected 0", tick_out[0]); end
    tests++; if (clock_out[0] !== 1'b0) begin fails++; $display("FAIL gap_resume_clk: got %b expected 0", clock_out[0]); end
    @(negedge clock_in);
    tests++; if (tick_out[0] !== 1'b1) begin fails++; $display("FAIL gap_final_tick: got %b expected 1", tick_out[0]); end
  endtask

  task automatic test_sync_clear();
    logic [1:0] et;
    load_valid = 1'b1; load_chan = 1'b1; load_div = 8'd4;
    tests++; if (load_ready !== 1'b1) begin fails++; $display("FAIL clr_ready: got %b expected 1", load_ready); end
    @(negedge clock_in);  // ch1 wrapping -> div 4 now; channels out of phase
    load_valid = 1'b0; sync_clear = 1'b1;
    @(negedge clock_in);
    sync_clear = 1'b0;
    tests++; if (tick_out !== 2'b00) begin fails++; $display("FAIL clr_tick: got %b expected 00", tick_out); end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock_in);
      et = (k % 4 == 0) ? 2'b11 : 2'b00;
      tests++; if (tick_out !== et) begin fails++; $display("FAIL clr_phase cyc %0d: got %b expected %b", k, tick_out, et); end
    end
  endtask

  task automatic test_reset_pending();
    int n;
    @(negedge clock_in);  // cnt0 == 1
    load_valid = 1'b1; load_chan = 1'b0; load_div = 8'd6;
    @(negedge clock_in);
    load_valid = 1'b0;
    tests++; if (load_ready !== 1'b0) begin fails++; $display("FAIL rst_pend_ready: got %b expected 0", load_ready); end
    tests++; if (clock_out[0] !== DUTY) begin fails++; $display("FAIL rst_pre_clk: got %b expected %b", clock_out[0], DUTY); end
    #2 reset_n = 1'b0;
    #1;
    tests++; if (tick_out !== 2'b00) begin fails++; $display("FAIL rst_mid_tick: got %b expected 00", tick_out); end
    tests++; if (clock_out !== 2'b00) begin fails++; $display("FAIL rst_mid_clk: got %b expected 00", clock_out); end
    tests++; if (load_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready: got %b expected 1", load_ready); end
    @(negedge clock_in);
    reset_n = 1'b1;
    wait_tick(0, n);
    tests++; if (n !== 4) begin fails++; $display("FAIL rst_first_period: got %0d expected 4", n); end
    wait_tick(0, n);
    tests++; if (n !== 4) begin fails++; $display("FAIL rst_second_period: got %0d expected 4", n); end
    tests++; if (load_ready !== 1'b1) begin fails++; $display("FAIL rst_post_ready: got %b expected 1", load_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load_deferred();
    test_load_zero_disabled();
    test_enable_gap();
    test_sync_clear();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clock_divider_multi.md
# clock_divider_multi

Parametrised multi-channel clock divider: a successor to the single fixed 1 Hz divider. It produces independent, runtime-programmable division on several channels from one system clock. Each channel provides a single-cycle tick strobe and, optionally, a near-50% duty square wave. It sits between the 50 MHz board clock and the stopwatch timebase, display-scan and debounce logic. Divisors are reloaded through a valid/ready handshake and applied glitch-free at period boundaries.

## Interface
Parameters:
- CHANNELS, 4, number of independent divider channels (1..16)
- WIDTH, 28, counter and divisor width in bits
- DEFAULT_DIV, 28'd50000000, divisor loaded into every channel on reset

Ports:
- clock_in  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- enable  input  CHANNELS  per-channel count enable
- sync_clear  input  1  synchronous restart of all channels
- load_valid  input  1  divisor load request
- load_chan  input  $clog2(CHANNELS) (min 1)  target channel of load
- load_div  input  WIDTH  new divisor value
- load_ready  output  1  load accepted when load_valid && load_ready
- tick_out  output  CHANNELS  one-cycle strobe per completed period
- clock_out  output  CHANNELS  divided square wave

## Operation
- Per channel: counter cnt in 0..div-1, active divisor div, shadow divisor shd, flag pend.
- Reset (async, reset_n low): cnt=0, div=DEFAULT_DIV, pend=0, tick_out=0, clock_out=0. A pending load is discarded.
- Wrap: enable[i] && cnt==div-1.
  - Wrap sets cnt<=0, else enable[i] sets cnt<=cnt+1.
  - enable[i] low: cnt holds, clock_out[i] holds, tick_out[i]=0.
- tick_out[i] <= wrap.
- clock_out[i] <= (cnt < div/2) when enabled. div/2 is integer division.
- Load handshake:
  - load_ready = !pend[load_chan] (combinational). It is 1 when load_chan >= CHANNELS; such loads are accepted and dropped.
  - On accept, load_div==0 is stored as 1.
  - If channel i is disabled or wrapping in the accept cycle, div<=value immediately.
  - Otherwise shd<=value and pend<=1. At the next wrap, div<=shd and pend<=0.
- sync_clear has highest priority after reset: all cnt<=0, all pending loads applied, pend<=0, tick_out<=0. load_valid in the same cycle is accepted and applied immediately.
- The divisor is never changed mid-period on an enabled channel.

## Timing
- Period is div enabled cycles. tick_out[i] is high in the cycle after the edge where cnt==div-1.
- From reset release with enable held high: first tick is registered on edge div and visible for one cycle.
- clock_out lags cnt by one cycle: high for div/2 cycles, low for div-div/2 cycles.
- div=1: tick_out[i] high every enabled cycle, clock_out[i] constant 0.
- Load to effect: up to one full current period. load_ready stays low on that channel until the applying wrap; it re-asserts the cycle after.
- No combinational path from enable or sync_clear to any output. Only load_ready is combinational, from load_chan.

## Configuration
- CLKDIV_DUTY_OUT_EN defined: clock_out generated as above.
- Not defined: clock_out tied to 0 and the comparators are removed. The port remains. Ticks and loads are unchanged.

## Test plan
Bench settings: CHANNELS=2, WIDTH=8, DEFAULT_DIV=4.
- Release reset, enable=2'b11 -> tick_out[0] high 1 cycle in 4; clock_out[0] pattern 1,1,0,0 repeating.
- At cnt[0]==1, load chan 0 div 6 -> load_ready drops. The current period completes at 4 cycles, next tick gap is 6, and load_ready re-rises after the wrap.
- Load chan 1 div 0 while enable[1]=0, then enable -> tick_out[1] every cycle, clock_out[1]=0.
- Drop enable[0] for 3 cycles at cnt==2 -> tick gap 7 cycles, no tick while disabled, clock_out[0] held.
- Channels at different phases, pulse sync_clear -> both cnt=0, then tick_out[0] and tick_out[1] coincide every 4 cycles.
- Assert reset_n low mid-period with pend[0]=1 -> tick_out=0 and clock_out=0 immediately; after release, period is 4 and load_ready=1.
